pulsar_adc_rd: RTL and testbench
================================

PULSAR_ADC_RD -- requirements
Module: pulsar_adc_rd

Interface
REQ-001 SHALL have parameter NCH, default 2, number of ADCs sharing cnv/sck, each with its own SDO lane (1..8).
REQ-002 SHALL have parameter BITS, default 16, bits per conversion (8..32).
REQ-003 SHALL have parameter HDIV, default 1, clk cycles per sck half-period (>=1).
REQ-004 SHALL have parameter TCONV, default 80, clk cycles cnv is held high (>=1).
REQ-005 SHALL have parameter TQUIET, default 2, clk cycles with cnv low and sck low before the first sck rise (>=1).
REQ-006 SHALL have parameter PERIOD, default 200, clk cycles between auto-mode triggers (>=2).
REQ-007 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-008 clk  input  1  system clock.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 start  input  1  single-shot frame request, one-cycle strobe.
REQ-011 auto_en  input  1  level; when high, frames trigger every PERIOD cycles.
REQ-012 clr_ovr  input  1  clears overrun.
REQ-013 sdo  input  NCH  serial data, lane k from ADC k.
REQ-014 cnv  output  1  conversion start, active high.
REQ-015 sck  output  1  serial clock, idles low.
REQ-016 busy  output  1  high while a frame is in progress.
REQ-017 data  output  NCH*BITS  last frame; channel k at data[k*BITS +: BITS].
REQ-018 valid  output  1  one-cycle strobe when data updates.
REQ-019 overrun  output  1  sticky flag; a trigger was lost.

Function
REQ-020 SHALL implement states IDLE -> CONV -> QUIET -> SHIFT -> IDLE; all outputs registered.
REQ-021 IDLE: trigger (start, or auto tick) sampled at edge N -> CONV from cycle N+1, busy=1, cnv=1.
REQ-022 CONV: cnv=1 for exactly TCONV cycles, then QUIET.
REQ-023 QUIET: cnv=0, sck=0 for exactly TQUIET cycles, then SHIFT.
REQ-024 SHIFT: BITS bit periods; each is HDIV cycles sck=0 followed by HDIV cycles sck=1.
REQ-025 All NCH sdo lanes SHALL be sampled on the clk edge that drives sck 0->1, MSB first, into per-lane shifters.
REQ-026 After the last high half-period: sck=0, busy=0, data loaded from shifters, valid=1 for one cycle, state IDLE.
REQ-027 Frame length from trigger edge to valid SHALL be 1+TCONV+TQUIET+2*HDIV*BITS cycles.
REQ-028 data SHALL hold its value between valid strobes; it SHALL be unsigned raw bits with no sign extension.
REQ-029 Auto mode: free-running counter 0..PERIOD-1 while auto_en=1, tick at count PERIOD-1; counter held at 0 while auto_en=0.
REQ-030 A trigger arriving when not in IDLE SHALL be dropped and SHALL set overrun=1 on the next cycle.
REQ-031 start and an auto tick in the same cycle SHALL count as one trigger.
REQ-032 A trigger in the same cycle as valid SHALL be accepted (state is IDLE that cycle).
REQ-033 overrun SHALL clear on clr_ovr; if clr_ovr and a new drop coincide, overrun SHALL stay 1.

Reset
REQ-034 rst SHALL force next cycle: state IDLE, cnv=0, sck=0, busy=0, valid=0, overrun=0, data=0, shifters=0, all counters 0.
REQ-035 rst mid-frame SHALL abort without a valid strobe; after rst deasserts, no frame starts until a new trigger arrives.

Verification
REQ-036 NCH=2,BITS=16,HDIV=2,TCONV=4,TQUIET=1; start at cycle 0 -> cnv=1 cycles 1-4, first sck rise cycle 8, valid cycle 70.
REQ-037 Same config; lane0 drives 0xA5C3, lane1 drives 0x1234 MSB first -> data=0x1234A5C3 at valid.
REQ-038 start again at cycle 30 of a frame -> ignored; overrun=1 from cycle 31; clr_ovr -> overrun=0.
REQ-039 auto_en=1, PERIOD=100 -> triggers at 100-cycle spacing, no overrun; PERIOD=50 -> overrun set.
REQ-040 rst at cycle 20 of a frame -> cnv/sck/busy=0 next cycle, no valid, data=0.
REQ-041 start coincident with valid -> new frame cnv=1 on the next cycle, no overrun.

Source files
------------

// File: rtl/pulsar_adc_rd.sv
// pulsar_adc_rd
// Frame controller for NCH PulSAR-style SAR ADCs sharing one cnv and one sck,
// each with its own SDO lane. A frame raises cnv for TCONV cycles, keeps cnv
// and sck low for TQUIET cycles, then clocks out BITS bits MSB first. All
// lanes are sampled on the clk edge that drives sck 0->1.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   start    in   one-cycle frame request
//   auto_en  in   level; frames are requested every PERIOD cycles while high
//   clr_ovr  in   clears overrun
//   sdo      in   [NCH]       serial data, lane k from ADC k
//   cnv      out  conversion start, active high
//   sck      out  serial clock, idles low
//   busy     out  frame in progress
//   data     out  [NCH*BITS]  last frame; channel k at data[k*BITS +: BITS]
//   valid    out  one-cycle strobe when data updates
//   overrun  out  sticky; a trigger arrived outside IDLE and was dropped
//
// state    | meaning
// ST_IDLE  | waiting for start or auto tick
// ST_CONV  | cnv high, ADCs converting (TCONV cycles)
// ST_QUIET | cnv and sck low before the first sck rise (TQUIET cycles)
// ST_SHIFT | BITS sck periods, HDIV cycles low then HDIV cycles high each

module pulsar_adc_rd #(
  parameter int NCH    = 2,
  parameter int BITS   = 16,
  parameter int HDIV   = 1,
  parameter int TCONV  = 80,
  parameter int TQUIET = 2,
  parameter int PERIOD = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic                 clr_ovr,
  input  logic [NCH-1:0]       sdo,
  output logic                 cnv,
  output logic                 sck,
  output logic                 busy,
  output logic [NCH*BITS-1:0]  data,
  output logic                 valid,
  output logic                 overrun
);

  localparam int TM1  = (TCONV > TQUIET) ? TCONV : TQUIET;
  localparam int TMAX = (TM1 > HDIV) ? TM1 : HDIV;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(PERIOD);
  localparam int BW   = $clog2(BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_QUIET = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  state_t              r_state, w_state_n;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic [BW-1:0]       r_bit, w_bit_n;
  logic [AW-1:0]       r_acnt;
  logic                r_cnv, w_cnv_n;
  logic                r_sck, w_sck_n;
  logic                r_busy, w_busy_n;
  logic                r_valid, w_valid_n;
  logic                r_ovr, w_ovr_n;
  logic [NCH*BITS-1:0] r_data, w_data_n;
  logic [NCH*BITS-1:0] r_shift, w_shift_n;

  logic w_tick;
  logic w_trig;

  // start and an auto tick in the same cycle collapse into a single trigger
  assign w_tick = auto_en && (r_acnt == AW'(PERIOD - 1));
  assign w_trig = start || w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acnt <= '0;
    end else if (!auto_en || w_tick) begin
      r_acnt <= '0;
    end else begin
      r_acnt <= r_acnt + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_cnv   <= 1'b0;
      r_sck   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_data  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_cnv   <= w_cnv_n;
      r_sck   <= w_sck_n;
      r_busy  <= w_busy_n;
      r_valid <= w_valid_n;
      r_ovr   <= w_ovr_n;
      r_data  <= w_data_n;
      r_shift <= w_shift_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_cnv_n   = r_cnv;
    w_sck_n   = r_sck;
    w_busy_n  = r_busy;
    w_valid_n = 1'b0;
    w_ovr_n   = r_ovr;
    w_data_n  = r_data;
    w_shift_n = r_shift;

    // a drop in the same cycle as clr_ovr wins so the lost trigger is not hidden
    if (clr_ovr) begin
      w_ovr_n = 1'b0;
    end
    if (w_trig && (r_state != ST_IDLE)) begin
      w_ovr_n = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_state_n = ST_CONV;
          w_cnv_n   = 1'b1;
          w_busy_n  = 1'b1;
          w_cnt_n   = CW'(TCONV - 1);
        end
      end
      ST_CONV: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - CW'(1);
        end else begin
          w_state_n = ST_QUIET;
          w_cnv_n   = 1'b0;
          w_cnt_n   = CW'(TQUIET - 1);
        end
      end
      ST_QUIET: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - CW'(1);
        end else begin
          w_state_n = ST_SHIFT;
          w_sck_n   = 1'b0;
          w_cnt_n   = CW'(HDIV - 1);
          w_bit_n   = BW'(BITS - 1);
        end
      end
      ST_SHIFT: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - CW'(1);
        end else if (!r_sck) begin
          // end of low half: raise sck and capture every lane on this edge
          w_sck_n = 1'b1;
          w_cnt_n = CW'(HDIV - 1);
          for (int k = 0; k < NCH; k++) begin
            w_shift_n[k*BITS +: BITS] = {r_shift[k*BITS +: BITS-1], sdo[k]};
          end
        end else if (r_bit == '0) begin
          w_state_n = ST_IDLE;
          w_sck_n   = 1'b0;
          w_busy_n  = 1'b0;
          w_valid_n = 1'b1;
          w_data_n  = r_shift;
        end else begin
          w_sck_n = 1'b0;
          w_cnt_n = CW'(HDIV - 1);
          w_bit_n = r_bit - BW'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign cnv     = r_cnv;
  assign sck     = r_sck;
  assign busy    = r_busy;
  assign data    = r_data;
  assign valid   = r_valid;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_pulsar_adc_rd.sv
module tb_pulsar_adc_rd;

  localparam int NCH = 2;
  localparam int BITS = 16;

  logic clk = 1'b0;
  logic rst, start, auto_en, clr_ovr;
  logic [NCH-1:0] sdo;
  logic cnv, sck, busy, valid, overrun;
  logic [NCH*BITS-1:0] data;

  logic start50, auto50, clr50;
  logic cnv50, sck50, busy50, valid50, overrun50;
  logic [NCH*BITS-1:0] data50;

  logic [15:0] w0, w1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulsar_adc_rd #(.NCH(NCH), .BITS(BITS), .HDIV(2), .TCONV(4), .TQUIET(1), .PERIOD(100)) u_dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .clr_ovr(clr_ovr),
    .sdo(sdo), .cnv(cnv), .sck(sck), .busy(busy), .data(data), .valid(valid),
    .overrun(overrun)
  );

  pulsar_adc_rd #(.NCH(NCH), .BITS(BITS), .HDIV(2), .TCONV(4), .TQUIET(1), .PERIOD(50)) u_dut50 (
    .clk(clk), .rst(rst), .start(start50), .auto_en(auto50), .clr_ovr(clr50),
    .sdo(sdo), .cnv(cnv50), .sck(sck50), .busy(busy50), .data(data50), .valid(valid50),
    .overrun(overrun50)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ADC model: MSB presented after cnv, next bit after each sck fall
  initial begin
    int idx;
    logic ps;
    idx = 0;
    ps = 1'b0;
    sdo = '0;
    forever begin
      @(negedge clk);
      if (cnv) idx = 0;
      else if (ps && !sck) idx++;
      ps = sck;
      if (idx > 15) idx = 15;
      sdo = {w1[15-idx], w0[15-idx]};
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid data=%0h at cyc %0d", data, cyc);
      end else begin
        e_mon = q.pop_front();
        chk("sb_data", 64'(data), 64'(e_mon.d));
        chk("sb_cycle", 64'(cyc), 64'(e_mon.c));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int s, a, fc, lc, sf, guard;
    rst = 1'b1; start = 1'b0; auto_en = 1'b0; clr_ovr = 1'b0;
    start50 = 1'b0; auto50 = 1'b0; clr50 = 1'b0;
    w0 = '0; w1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_cnv", 64'(cnv), 0);
    chk("rst_sck", 64'(sck), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_ovr", 64'(overrun), 0);
    chk("rst_data", 64'(data), 0);
    chk("rst50_outs", {cnv50, sck50, busy50, valid50, overrun50}, 0);
    chk("rst50_data", 64'(data50), 0);
    rst = 1'b0;
    @(negedge clk);

    // frame 1: timing and basic data
    w0 = 16'hA5C3; w1 = 16'h1234;
    s = cyc;
    q.push_back('{32'h1234A5C3, s + 70});
    pulse_start();
    fc = -1; lc = -1; sf = -1;
    while (cyc <= s + 70) begin
      if (cnv) begin
        if (fc < 0) fc = cyc;
        lc = cyc;
      end
      if (sck && sf < 0) sf = cyc;
      if (cyc == s + 69) chk("busy_last", 64'(busy), 1);
      if (cyc == s + 70) begin
        chk("busy_done", 64'(busy), 0);
        chk("sck_done", 64'(sck), 0);
      end
      @(negedge clk);
    end
    chk("cnv_first", 64'(fc), 64'(s + 1));
    chk("cnv_last", 64'(lc), 64'(s + 4));
    chk("sck_first", 64'(sf), 64'(s + 8));
    chk("ovr_f1", 64'(overrun), 0);

    // frame 2: dropped trigger, overrun set, clear racing a drop
    repeat (5) @(negedge clk);
    w0 = 16'h8001; w1 = 16'h7FFE;
    s = cyc;
    q.push_back('{32'h7FFE8001, s + 70});
    pulse_start();
    wait_cyc(s + 30);
    chk("ovr_before_drop", 64'(overrun), 0);
    pulse_start();
    chk("ovr_set", 64'(overrun), 1);
    wait_cyc(s + 40);
    start = 1'b1; clr_ovr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_ovr = 1'b0;
    chk("ovr_clr_vs_drop", 64'(overrun), 1);
    wait_cyc(s + 75);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_clr", 64'(overrun), 0);

    // frame 3: start coincident with valid
    w0 = 16'h0F0F; w1 = 16'hF0F0;
    s = cyc;
    q.push_back('{32'hF0F00F0F, s + 70});
    q.push_back('{32'hF0F00F0F, s + 140});
    pulse_start();
    wait_cyc(s + 70);
    chk("b2b_valid", 64'(valid), 1);
    pulse_start();
    chk("b2b_cnv", 64'(cnv), 1);
    chk("b2b_ovr", 64'(overrun), 0);
    wait_cyc(s + 145);

    // reset mid-frame
    w0 = 16'h5555; w1 = 16'hAAAA;
    s = cyc;
    pulse_start();
    wait_cyc(s + 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_cnv", 64'(cnv), 0);
    chk("rstmid_sck", 64'(sck), 0);
    chk("rstmid_busy", 64'(busy), 0);
    chk("rstmid_data", 64'(data), 0);
    repeat (100) @(negedge clk);
    chk("rstmid_idle", 64'(busy), 0);

    // auto mode: PERIOD=100 no overrun, PERIOD=50 overrun
    w0 = 16'hC3A5; w1 = 16'h4321;
    a = cyc;
    q.push_back('{32'h4321C3A5, a + 169});
    q.push_back('{32'h4321C3A5, a + 269});
    auto_en = 1'b1; auto50 = 1'b1;
    wait_cyc(a + 99);
    chk("auto_cnv_pre", 64'(cnv), 0);
    chk("auto50_ovr_pre", 64'(overrun50), 0);
    @(negedge clk);
    chk("auto_cnv_tick", 64'(cnv), 1);
    chk("auto50_ovr_set", 64'(overrun50), 1);
    wait_cyc(a + 271);
    auto_en = 1'b0; auto50 = 1'b0;
    chk("auto_ovr", 64'(overrun), 0);
    repeat (80) @(negedge clk);
    chk("auto_stopped", 64'(busy), 0);
    chk("auto50_stopped", 64'(busy50), 0);

    guard = 0;
    while (q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("sb_empty", 64'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
